// File: rtl/imm_assembler.sv
// Gathers WIDTH/8 bytes (little-endian) from a valid/ready byte stream into one immediate and
// holds it, together with its sign/zero-extension flag, until the downstream stage acknowledges it.
module imm_assembler #(
  parameter int WIDTH = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [7:0]       iData,
  input  logic             iValid,
  output logic             oReady,
  input  logic             iSext,
  input  logic             iAbort,
  output logic [WIDTH-1:0] oImm,
  output logic             oSext,
  output logic             oValid,
  input  logic             iAck
);

  localparam int BYTES = WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   imm_q,   imm_d;
  logic               sext_q,  sext_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    imm_d   = imm_q;
    sext_d  = sext_q;

    case (state_q)
      COLLECT: begin
        // Abort wins over a byte offered in the same cycle; stale bytes stay in imm.
        if (iAbort) begin
          cnt_d = '0;
        end else if (iValid) begin
          for (int i = 0; i < BYTES; i++) begin
            if (cnt_q == CNT_W'(i)) imm_d[8*i +: 8] = iData;
          end
          if (cnt_q == LAST) begin
            sext_d  = iSext;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (iAck) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase

    // Handshake outputs are registered copies of the next state: no input-to-output path.
    ready_d = (state_d == COLLECT);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      imm_q   <= '0;
      sext_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      imm_q   <= imm_d;
      sext_q  <= sext_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign oReady = ready_q;
  assign oValid = valid_q;
  assign oImm   = imm_q;
  assign oSext  = sext_q;

endmodule

// File: tb/tb_imm_assembler.sv
// Bench for imm_assembler: directed scenarios plus randomized traffic against a byte-array model.
module tb_imm_assembler;

  localparam int W  = 16;
  localparam int NB = W / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          iRst;
  logic [7:0]    iData;
  logic          iValid, iSext, iAbort, iAck;
  logic          oReady, oSext, oValid;
  logic [W-1:0]  oImm;

  logic [7:0]    d32;
  logic          v32;
  logic          r32, s32, ov32;
  logic [31:0]   imm32;

  int tests = 0;
  int fails = 0;

  imm_assembler #(.WIDTH(W)) u16 (
    .iClk(clk), .iRst(iRst), .iData(iData), .iValid(iValid), .oReady(oReady),
    .iSext(iSext), .iAbort(iAbort), .oImm(oImm), .oSext(oSext), .oValid(oValid), .iAck(iAck)
  );

  imm_assembler #(.WIDTH(32)) u32 (
    .iClk(clk), .iRst(iRst), .iData(d32), .iValid(v32), .oReady(r32),
    .iSext(1'b0), .iAbort(1'b0), .oImm(imm32), .oSext(s32), .oValid(ov32), .iAck(1'b1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: byte slots, count of bytes collected, hold flag, captured mode.
  logic [7:0] m_b [NB];
  int         m_n;
  bit         m_hold;
  bit         m_sext;

  always @(posedge clk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < NB; i++) m_b[i] = 8'h00;
      m_n = 0; m_hold = 0; m_sext = 0;
    end else if (m_hold) begin
      if (iAck) m_hold = 0;
    end else if (iAbort) begin
      m_n = 0;
    end else if (iValid) begin
      m_b[m_n] = iData;
      if (m_n == NB - 1) begin
        m_sext = iSext; m_n = 0; m_hold = 1;
      end else begin
        m_n = m_n + 1;
      end
    end
  end

  function automatic logic [W-1:0] model_imm();
    logic [W-1:0] r = '0;
    for (int i = 0; i < NB; i++) r = r | (W'(m_b[i]) << (8 * i));
    return r;
  endfunction

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (!iRst) begin
      check("cmp_valid", 64'(oValid), 64'(m_hold));
      check("cmp_ready", 64'(oReady), 64'(!m_hold));
      check("cmp_imm",   64'(oImm),   64'(model_imm()));
      check("cmp_sext",  64'(oSext),  64'(m_sext));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic ab, input logic ack);
    iValid = v; iData = d; iSext = s; iAbort = ab; iAck = ack;
  endtask

  function automatic logic [31:0] extend_b(input logic [15:0] a, input logic sx);
    return {{16{sx & a[15]}}, a};
  endfunction

  initial begin
    iRst = 1'b1;
    drive(0, 8'h00, 0, 0, 0);
    d32 = 8'h00; v32 = 1'b0;
    #1;
    check("reset_valid", 64'(oValid), 64'd0);
    check("reset_ready", 64'(oReady), 64'd1);
    check("reset_imm",   64'(oImm),   64'h0);
    check("reset_sext",  64'(oSext),  64'd0);
    step(); step();
    iRst = 1'b0;
    step();

    // Back-to-back bytes.
    drive(1, 8'h34, 0, 0, 0); step();
    check("first_byte_no_valid", 64'(oValid), 64'd0);
    drive(1, 8'h12, 1, 0, 0); step();
    check("b2b_valid", 64'(oValid), 64'd1);
    check("b2b_imm",   64'(oImm),   64'h1234);
    check("b2b_sext",  64'(oSext),  64'd1);
    check("b2b_ready", 64'(oReady), 64'd0);

    // HOLD ignores iValid.
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'hFF, 0, 0, 0); step();
      check("hold_imm",   64'(oImm),   64'h1234);
      check("hold_valid", 64'(oValid), 64'd1);
    end
    drive(0, 8'h00, 0, 0, 1); step();
    check("ack_valid", 64'(oValid), 64'd0);
    check("ack_ready", 64'(oReady), 64'd1);
    check("ack_imm_kept", 64'(oImm), 64'h1234);

    // Abort drops the partial word and the byte offered with it.
    drive(1, 8'hAA, 0, 0, 0); step();
    drive(1, 8'hBB, 0, 1, 0); step();
    check("abort_no_valid", 64'(oValid), 64'd0);
    drive(1, 8'h00, 0, 0, 0); step();
    drive(1, 8'h80, 0, 0, 0); step();
    check("abort_imm",   64'(oImm),   64'h8000);
    check("abort_sext",  64'(oSext),  64'd0);
    check("abort_valid", 64'(oValid), 64'd1);
    drive(0, 8'h00, 0, 1, 1); step();
    check("abort_in_hold_then_ack", 64'(oValid), 64'd0);

    // Gapped input.
    drive(1, 8'h01, 0, 0, 0); step();
    drive(0, 8'h00, 0, 0, 0); step(); step();
    check("gap_no_valid", 64'(oValid), 64'd0);
    drive(1, 8'h80, 1, 0, 0); step();
    check("gap_imm",  64'(oImm),  64'h8001);
    check("gap_sext", 64'(oSext), 64'd1);
    check("gap_extend_b", 64'(extend_b(oImm, oSext)), 64'hFFFF8001);
    drive(0, 8'h00, 0, 0, 1); step();

    // Asynchronous reset mid-word.
    drive(1, 8'h34, 0, 0, 0); step();
    drive(0, 8'h00, 0, 0, 0);
    #1 iRst = 1'b1;
    #1;
    check("midreset_valid", 64'(oValid), 64'd0);
    check("midreset_ready", 64'(oReady), 64'd1);
    check("midreset_imm",   64'(oImm),   64'h0);
    check("midreset_sext",  64'(oSext),  64'd0);
    #2 iRst = 1'b0;
    step();

    // WIDTH=32 with iAck tied high.
    v32 = 1'b1; d32 = 8'h78; step();
    d32 = 8'h56; step();
    d32 = 8'h34; step();
    check("w32_not_yet", 64'(ov32), 64'd0);
    d32 = 8'h12; step();
    check("w32_valid", 64'(ov32), 64'd1);
    check("w32_imm",   64'(imm32), 64'h12345678);
    check("w32_ready_low", 64'(r32), 64'd0);
    d32 = 8'hAA; step();
    check("w32_valid_one_cycle", 64'(ov32), 64'd0);
    check("w32_ready_back", 64'(r32), 64'd1);
    step();
    check("w32_next_first_byte", 64'(imm32), 64'h123456AA);
    v32 = 1'b0;
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        drive(0, 8'h00, 0, 0, 0);
        iRst = 1'b1; step(); iRst = 1'b0;
      end else begin
        drive($urandom_range(0, 99) < 70, 8'($urandom), 1'($urandom),
              $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 40);
        step();
      end
    end

    drive(0, 8'h00, 0, 0, 0);
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
